// File: rtl/bcd_to_bin_seq.sv
// ============================================================================
// bcd_to_bin_seq : sequential BCD-to-binary converter (reverse double dabble)
// Revision 1.0
// ============================================================================
`default_nettype none

module bcd_to_bin_seq #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   bcd_in,
  output logic [BIN_W-1:0]      bin_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q;
  logic [BCD_W-1:0]   bcd_q;
  logic [BIN_W-1:0]   bin_q;
  logic [CNT_W-1:0]   count_q;
  logic [BIN_W-1:0]   bin_out_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;

  logic [BCD_W-1:0]   bcd_sh;
  logic [BCD_W-1:0]   bcd_d;
  logic [BIN_W-1:0]   bin_d;
  logic               in_bad;

  // One reverse-dabble step: shift right, then pull each digit >=8 back by 3.
  always_comb begin
    bcd_sh = {1'b0, bcd_q[BCD_W-1:1]};
    bin_d  = {bcd_q[0], bin_q[BIN_W-1:1]};
    bcd_d  = bcd_sh;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_sh[4*d +: 4] >= 4'd8) begin
        bcd_d[4*d +: 4] = bcd_sh[4*d +: 4] - 4'd3;
      end
    end
  end

  always_comb begin
    in_bad = 1'b0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_in[4*d +: 4] > 4'd9) begin
        in_bad = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      bcd_q     <= '0;
      bin_q     <= '0;
      count_q   <= '0;
      bin_out_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            bcd_q   <= bcd_in;
            bin_q   <= '0;
            count_q <= '0;
            if (in_bad) begin
              state_q   <= S_DONE;
              done_q    <= 1'b1;
              err_q     <= 1'b1;
              bin_out_q <= '0;
            end else begin
              state_q <= S_SHIFT;
              busy_q  <= 1'b1;
              err_q   <= 1'b0;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_SHIFT: begin
          bcd_q   <= bcd_d;
          bin_q   <= bin_d;
          count_q <= count_q + 1'b1;
          // Last shift: publish the freshly shifted value, never a partial one.
          if (count_q == CNT_W'(BIN_W - 1)) begin
            bin_out_q <= bin_d;
            state_q   <= S_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bin_out = bin_out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_to_bin_seq.sv
// ============================================================================
// tb_bcd_to_bin_seq : randomized self-checking bench against a decimal model
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_bcd_to_bin_seq;

  localparam int DIGITS = 4;
  localparam int BIN_W  = 14;

  logic                clk;
  logic                rst_n;
  logic                start;
  logic [4*DIGITS-1:0] bcd_in;
  logic [BIN_W-1:0]    bin_out;
  logic                busy;
  logic                done;
  logic                err;

  int n_cmp;
  int n_mis;

  bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .bcd_in  (bcd_in),
    .bin_out (bin_out),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Decimal value of the digits, plus whether any digit is out of range.
  function automatic void ref_model(input logic [4*DIGITS-1:0] b, output int val, output bit bad);
    int dg;
    val = 0;
    bad = 1'b0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      dg = int'(b[4*k +: 4]);
      if (dg > 9) bad = 1'b1;
      val = val * 10 + dg;
    end
  endfunction

  function automatic logic [4*DIGITS-1:0] rand_bcd(input bit allow_bad);
    logic [4*DIGITS-1:0] b;
    for (int k = 0; k < DIGITS; k++) begin
      if (allow_bad && $urandom_range(0, 9) == 0)
        b[4*k +: 4] = 4'($urandom_range(10, 15));
      else
        b[4*k +: 4] = 4'($urandom_range(0, 9));
    end
    return b;
  endfunction

  task automatic run_conv(input logic [4*DIGITS-1:0] b, input bit noisy);
    int                val;
    bit                bad;
    int                k;
    int                busy_n;
    bit                stable;
    logic [BIN_W-1:0]  prev;
    ref_model(b, val, bad);
    prev   = bin_out;
    stable = 1'b1;
    bcd_in = b;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    check("err_cycle1", err, bad);
    k      = 1;
    busy_n = 0;
    while (done !== 1'b1 && k < 40) begin
      if (busy === 1'b1) busy_n++;
      if (bin_out !== prev) stable = 1'b0;
      if (noisy) begin
        bcd_in = 16'($urandom);
        start  = 1'($urandom_range(0, 1));
      end
      tick();
      k++;
    end
    start = 1'b0;
    check("latency", k, bad ? 1 : BIN_W + 1);
    check("busy_cycles", busy_n, bad ? 0 : BIN_W);
    if (!bad) check("no_partial", stable, 1);
    check("bin_out", bin_out, bad ? 0 : val);
    check("err", err, bad);
    check("busy_at_done", busy, 0);
    bcd_in = 16'($urandom);
    tick();
    check("done_one_cycle", done, 0);
    check("bin_out_held", bin_out, bad ? 0 : val);
    check("err_held", err, bad);
  endtask

  initial begin
    int pulses;
    int cnt;
    n_cmp  = 0;
    n_mis  = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    bcd_in = '0;
    #1;
    check("rst_bin_out", bin_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    run_conv(16'h9999, 1'b0);
    run_conv(16'h0000, 1'b0);
    run_conv(16'h1234, 1'b0);
    run_conv(16'h12A4, 1'b0);
    run_conv(16'h0050, 1'b1);
    run_conv(16'hF000, 1'b0);
    run_conv(16'h0001, 1'b0);
    run_conv(16'h0008, 1'b0);

    // Back-to-back conversions with start held high.
    pulses = 0;
    bcd_in = 16'h0001;
    start  = 1'b1;
    for (int c = 1; c <= 3 * (BIN_W + 1); c++) begin
      tick();
      if (done === 1'b1) begin
        pulses++;
        check("hold_phase", c % (BIN_W + 1), 0);
        check("hold_bin", bin_out, 1);
      end
    end
    start = 1'b0;
    check("hold_pulses", pulses, 3);
    tick();

    // Reset in the middle of a conversion.
    run_conv(16'h0777, 1'b0);
    bcd_in = 16'h4321;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    check("abort_bin_out", bin_out, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_err", err, 0);
    tick();
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) cnt++;
    end
    check("abort_quiet", cnt, 0);
    run_conv(16'h4321, 1'b0);

    // Random mix of valid and invalid operands, some with noise while busy.
    for (int i = 0; i < 30; i++) begin
      run_conv(rand_bcd(1'b1), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

`default_nettype wire
